// File: rtl/quad_decoder_pkg.sv
// Shared types and constants for the quadrature decoder.
// Gray-code states, direction constants and the transition classifier.
package quad_decoder_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic {
    PH_INIT = 1'b0,
    PH_RUN  = 1'b1
  } qd_phase_e;

  typedef struct packed {
    qd_phase_e  phase;
    logic [1:0] prev;
  } qd_dbg_t;

  // Returns {legal, up}; legal means exactly one of A/B changed.
  function automatic logic [1:0] qd_classify(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] fwd;
    logic       legal;
    logic       up;
    case (prev)
      QS_00:   fwd = QS_01;
      QS_01:   fwd = QS_11;
      QS_11:   fwd = QS_10;
      default: fwd = QS_00;
    endcase
    legal = ^(prev ^ curr);
    up    = (curr == fwd) ? DIR_UP : DIR_DN;
    return {legal, up};
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side and count-side signals of the quadrature decoder.
// idx_i exists only when QUAD_DECODER_INDEX_EN is defined.
interface quad_decoder_if
  import quad_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic             a_i;
  logic             b_i;
  logic             en_i;
  logic             clr_err_i;
`ifdef QUAD_DECODER_INDEX_EN
  logic             idx_i;
`endif
  logic [CNT_W-1:0] pos_o;
  logic             step_o;
  logic             dir_o;
  logic             err_o;
  qd_dbg_t          dbg_o;

  // No valid/ready pair here: step_o is a one-cycle strobe that qualifies
  // dir_o and the new pos_o; consumers must sample it every cycle.
`ifdef QUAD_DECODER_INDEX_EN
  modport master (input a_i, b_i, en_i, clr_err_i, idx_i,
                  output pos_o, step_o, dir_o, err_o, dbg_o);
  modport slave  (output a_i, b_i, en_i, clr_err_i, idx_i,
                  input pos_o, step_o, dir_o, err_o, dbg_o);
`else
  modport master (input a_i, b_i, en_i, clr_err_i,
                  output pos_o, step_o, dir_o, err_o, dbg_o);
  modport slave  (output a_i, b_i, en_i, clr_err_i,
                  input pos_o, step_o, dir_o, err_o, dbg_o);
`endif

endinterface

// File: rtl/qdec_input_filter.sv
// Per-channel synchroniser followed by a stability filter: a level is
// accepted only after FILT_LEN consecutive equal synchronised samples.
module qdec_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic vld_o
);

  localparam int             CW = 4;
  localparam logic [CW-1:0]  FL = CW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp;
  logic                   last_q;
  logic                   filt_q;
  logic                   vld_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  assign samp = sync_q[SYNC_STAGES-1];

  // cnt_q == 0 only straight after reset, so the first sample always starts a run.
  always_comb begin
    cnt_d = CW'(1);
    if (samp == last_q && cnt_q != '0) begin
      cnt_d = (cnt_q >= FL) ? FL : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      last_q <= samp;
      cnt_q  <= cnt_d;
      if (cnt_d == FL) begin
        filt_q <= samp;
        vld_q  <= 1'b1;
      end
    end
  end

  assign q_o   = filt_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: filtered inputs -> step/dir pulses, wrapping
// position count and sticky illegal-transition flag. Macro QUAD_DECODER_INDEX_EN adds idx_i.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  quad_decoder_if.master bus
);

  logic a_f, b_f, a_vld, b_vld;
  logic idx_rise;

  qdec_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (bus.a_i), .q_o (a_f), .vld_o (a_vld)
  );

  qdec_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (bus.b_i), .q_o (b_f), .vld_o (b_vld)
  );

`ifdef QUAD_DECODER_INDEX_EN
  logic idx_f, idx_vld, idx_prev_q;

  qdec_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_idx (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (bus.idx_i), .q_o (idx_f), .vld_o (idx_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_prev_q <= 1'b0;
    else       idx_prev_q <= idx_f;
  end

  assign idx_rise = idx_vld & idx_f & ~idx_prev_q;
`else
  assign idx_rise = 1'b0;
`endif

  qd_phase_e        phase_q, phase_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       curr;
  logic [1:0]       cls;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  assign curr = {a_f, b_f};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_INIT;
      prev_q  <= QS_00;
    end else begin
      phase_q <= phase_d;
      prev_q  <= prev_d;
    end
  end

  // The reference state is loaded only once both channels have a filtered level.
  always_comb begin
    phase_d = phase_q;
    prev_d  = prev_q;
    case (phase_q)
      PH_INIT: begin
        if (a_vld && b_vld) begin
          phase_d = PH_RUN;
          prev_d  = curr;
        end
      end
      PH_RUN:  prev_d = curr;
      default: phase_d = PH_INIT;
    endcase
  end

  always_comb begin
    cls    = qd_classify(prev_q, curr);
    step_d = 1'b0;
    dir_d  = dir_q;
    err_d  = err_q & ~bus.clr_err_i;
    pos_d  = pos_q;
    if (phase_q == PH_RUN && curr != prev_q) begin
      if (cls[1]) begin
        step_d = 1'b1;
        dir_d  = cls[0];
        if (bus.en_i) begin
          pos_d = (cls[0] == DIR_UP) ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end
    // Index wins over a same-cycle count but leaves step/dir untouched.
    if (idx_rise) pos_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= DIR_DN;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
    end
  end

  assign bus.pos_o  = pos_q;
  assign bus.step_o = step_q;
  assign bus.dir_o  = dir_q;
  assign bus.err_o  = err_q;
  assign bus.dbg_o  = '{phase: phase_q, prev: prev_q};

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: a Gray-table model predicts each step
// (cycle, pos, dir) into a queue that a monitor pops on every step_o pulse.
module tb_quad_decoder;

  localparam int CNT_W = 8;
  localparam int LAT   = 6;
  localparam int W     = 32 + CNT_W + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  quad_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     e;
  int               chk_cnt = 0;
  int               err_cnt = 0;
  logic [1:0]       m_ab  = 2'b00;
  logic [CNT_W-1:0] m_pos = '0;
  logic             m_dir = 1'b0;
  logic             m_err = 1'b0;
  logic             m_idx = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.step_o) begin
        if (exp_q.size() == 0) begin
          check("unexp_step", 32'(bus.step_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("step_cyc", cyc, e[W-1 -: 32]);
          check("step_pos", 32'(bus.pos_o), 32'(e[CNT_W:1]));
          check("step_dir", 32'(bus.dir_o), 32'(e[0]));
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0][W-1 -: 32]) begin
        check("missing_step", 32'(bus.step_o), 32'd1);
        e = exp_q.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    int d;
    bit step;
    d    = (gidx(ab) - gidx(m_ab)) & 3;
    step = 1'b0;
    bus.a_i = ab[1];
    bus.b_i = ab[0];
    if (d == 1) begin
      step  = 1'b1;
      m_dir = 1'b1;
      if (bus.en_i) m_pos = m_pos + CNT_W'(1);
    end else if (d == 3) begin
      step  = 1'b1;
      m_dir = 1'b0;
      if (bus.en_i) m_pos = m_pos - CNT_W'(1);
    end else if (d == 2) begin
      m_err = 1'b1;
    end
`ifdef QUAD_DECODER_INDEX_EN
    if (bus.idx_i && !m_idx) m_pos = '0;
    m_idx = bus.idx_i;
`endif
    if (step) exp_q.push_back({cyc + LAT, m_pos, m_dir});
    m_ab = ab;
    tick(hold);
  endtask

  task automatic fwd(input int hold);
    drive_ab(gval(gidx(m_ab) + 1), hold);
  endtask

  task automatic rev(input int hold);
    drive_ab(gval(gidx(m_ab) + 3), hold);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    bus.a_i = ab[1];
    bus.b_i = ab[0];
    rst_i   = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_pos", 32'(bus.pos_o), 32'd0);
    check("rst_step", 32'(bus.step_o), 32'd0);
    check("rst_dir", 32'(bus.dir_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    exp_q.delete();
    m_ab  = ab;
    m_pos = '0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_idx = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick(12);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pos"}, 32'(bus.pos_o), 32'(m_pos));
    check({tag, "_dir"}, 32'(bus.dir_o), 32'(m_dir));
    check({tag, "_err"}, 32'(bus.err_o), 32'(m_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.a_i       = 1'b1;
    bus.b_i       = 1'b1;
    bus.en_i      = 1'b1;
    bus.clr_err_i = 1'b0;
`ifdef QUAD_DECODER_INDEX_EN
    bus.idx_i     = 1'b0;
`endif

    // Held 11 through reset release becomes the reference: no step, no error.
    do_reset(2'b11);
    tick(10);
    check_idle("init11");
    // 11 -> 01 is a reverse step only if 11 was taken as reference.
    rev(10);
    check_idle("init_rev");

    // Forward sequence 00,01,11,10,00.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) fwd(10);
    check_idle("fwd4");

    // Wrap down from 0, then 256 forward steps back to 255.
    do_reset(2'b00);
    drive_ab(2'b10, 10);
    check_idle("wrap_dn");
    for (int i = 0; i < 256; i++) fwd(6);
    tick(4);
    check_idle("wrap_up");

    // Two-cycle glitch on A must be filtered out.
    bus.a_i = ~bus.a_i;
    tick(2);
    bus.a_i = m_ab[1];
    tick(15);
    check_idle("glitch");

    // Illegal jump sets the sticky error.
    drive_ab(~m_ab, 10);
    check_idle("illegal");

    // Clear coinciding with a second illegal jump: set wins.
    drive_ab(~m_ab, 5);
    bus.clr_err_i = 1'b1;
    tick(1);
    bus.clr_err_i = 1'b0;
    check("clr_vs_set", 32'(bus.err_o), 32'd1);
    tick(8);

    // Lone clear drops the flag on the next cycle.
    bus.clr_err_i = 1'b1;
    tick(1);
    bus.clr_err_i = 1'b0;
    m_err = 1'b0;
    check("clr_alone", 32'(bus.err_o), 32'd0);
    tick(4);

    // Count disabled: steps still pulse, pos holds.
    bus.en_i = 1'b0;
    for (int i = 0; i < 3; i++) fwd(8);
    check_idle("en_off");
    bus.en_i = 1'b1;

    // Random legal walk with random enable.
    for (int i = 0; i < 24; i++) begin
      bus.en_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) fwd($urandom_range(6, 12));
      else                          rev($urandom_range(6, 12));
    end
    bus.en_i = 1'b1;
    tick(4);
    check_idle("walk");

    // Reset with a change still in the filter; non-00 level at release is not a step.
    drive_ab(~m_ab, 10);
    bus.a_i = ~bus.a_i;
    tick(2);
    do_reset(2'b11);
    check_idle("rst_mid");
    fwd(10);
    check_idle("after_rst");

`ifdef QUAD_DECODER_INDEX_EN
    // Index rising with a forward step: pos loads 0, step/dir still pulse.
    do_reset(2'b00);
    for (int i = 0; i < 7; i++) fwd(8);
    check_idle("pre_idx");
    bus.idx_i = 1'b1;
    fwd(10);
    check_idle("idx_step");
    bus.idx_i = 1'b0;
    fwd(10);
    check_idle("post_idx");
`endif

    tick(20);
    check("pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Decodes two-channel quadrature (A/B) signals from a rotary or linear encoder into single-cycle step pulses, a direction flag and a wrapping position count.
- Sits upstream of the up/down counting logic and feeds position to control and status registers.
- Inputs are asynchronous to clk_i. They are synchronised and glitch-filtered before decoding.
- Illegal double transitions are flagged as a sticky error.

Parameters:
- CNT_W, 8, width of the position counter pos_o.
- SYNC_STAGES, 2, flip-flop stages per input synchroniser; legal range 2..4.
- FILT_LEN, 3, consecutive identical synchronised samples required before a new level is accepted; legal range 1..15.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- a_i  input  1  encoder channel A (asynchronous)
- b_i  input  1  encoder channel B (asynchronous)
- en_i  input  1  count enable; when low, decoding continues but pos_o holds
- clr_err_i  input  1  clears err_o (single-cycle pulse)
- pos_o  output  CNT_W  position count
- step_o  output  1  one-cycle pulse per legal quadrature transition
- dir_o  output  1  direction of the last legal step; 1=up, 0=down
- err_o  output  1  sticky illegal-transition flag

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: pos_o=0, step_o=0, dir_o=0, err_o=0. Synchroniser and filter registers clear to 0. The init flag is set.
- Per-channel filter:
  - A candidate level is accepted only after FILT_LEN consecutive equal samples at the synchroniser output.
  - A shorter pulse never reaches the decoder.
- Init:
  - The first accepted {A,B} pair after reset is loaded as the reference state.
  - No step, count or error occurs on that cycle. The init flag then clears.
- Decoder state: prev={A,B} from the filtered outputs. Gray order: 00→01→11→10→00.
- Forward transition (00→01, 01→11, 11→10, 10→00):
  - step_o=1 and dir_o=1 on the next cycle.
  - If en_i=1, pos_o increments by 1.
- Reverse transition:
  - step_o=1 and dir_o=0 on the next cycle.
  - If en_i=1, pos_o decrements by 1.
- No change: step_o=0. pos_o and dir_o hold.
- Illegal transition (both bits change, e.g. 00→11):
  - err_o=1 (sticky).
  - No step; pos_o and dir_o hold.
  - prev updates to the new state.
- Wrap: pos_o is arithmetic modulo 2^CNT_W. Up from all-ones gives 0; down from 0 gives all-ones. No saturation.
- Latency: a stable input edge to step_o takes SYNC_STAGES+FILT_LEN+1 cycles (6 with defaults). pos_o updates in the same cycle as step_o.
- Error clear:
  - clr_err_i=1 clears err_o on the next cycle.
  - If an illegal transition is detected in the same cycle, set wins and err_o stays 1.
- en_i low: step_o, dir_o and err_o still update. Only pos_o is frozen.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - Pending filter counts are discarded.
  - The init reload occurs again, so a non-00 level at release does not count.

Optional Feature:
- Macro QUAD_DECODER_INDEX_EN.
- Defined:
  - Adds port idx_i (input, 1 bit, asynchronous) with the same synchroniser and filter.
  - On a filtered rising edge of idx_i, pos_o loads 0. This takes priority over a same-cycle step, but step_o and dir_o still pulse.
  - Index is honoured even when en_i=0.
- Undefined: no idx_i port and no clear path; all other behaviour is identical.

Decomposition:
- Package quad_decoder_pkg:
  - State localparams QS_00, QS_01, QS_11, QS_10.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - A function returning {legal, up} for a (prev, curr) pair.
- Sub-module qdec_input_filter:
  - Contains the SYNC_STAGES synchroniser plus the FILT_LEN stability counter.
  - Instantiated per channel: A, B, and idx when enabled.

Test Plan:
- Reset, then hold A/B=11 through release → no step, err_o=0, pos_o=0; the first accepted state is taken as reference.
- Forward sequence 00,01,11,10,00 with each level held 10 cycles, en_i=1 → 4 step pulses, dir_o=1, pos_o=4; each step arrives 6 cycles after its edge.
- pos_o=0, then one reverse step 00→10 → pos_o=255 (CNT_W=8), dir_o=0; then 256 forward steps → pos_o=255.
- 2-cycle glitch on A with FILT_LEN=3 → no step, pos_o unchanged; 00→11 jump held → err_o=1, pos_o unchanged; clr_err_i coinciding with a second illegal jump → err_o remains 1; a later lone clr_err_i → err_o=0.
- en_i=0 during 3 forward steps → 3 step pulses, pos_o unchanged; rst_i asserted mid-sequence → all outputs 0 on the next cycle.
- QUAD_DECODER_INDEX_EN defined: pos_o=7, idx_i rises in the same cycle as a forward step → pos_o=0, step_o=1, dir_o=1.
